// File: rtl/wash_sequencer_pkg.sv
// Shared definitions for the wash programme: state codes, level limits and
// the per-mode phase ordering used by the sequencer and the display stage.
package wash_sequencer_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int WASH_SEC_DEF  = 9;
  localparam int RINSE_SEC_DEF = 6;
  localparam int SPIN_SEC_DEF  = 3;
  localparam int BUZZ_SEC_DEF  = 2;

  localparam logic [3:0] LVL_MIN   = 4'd2;
  localparam logic [3:0] LVL_MAX   = 4'd8;
  localparam logic [2:0] MODE_LAST = 3'd5;

  // Modes: 0 W+R+S, 1 W, 2 W+R, 3 R, 4 R+S, 5 S
  function automatic state_t first_phase(input logic [2:0] mode);
    state_t st;
    case (mode)
      3'd0, 3'd1, 3'd2: st = S_WASH;
      3'd3, 3'd4:       st = S_RINSE;
      default:          st = S_SPIN;
    endcase
    return st;
  endfunction

  function automatic state_t next_phase(input state_t cur, input logic [2:0] mode);
    state_t st;
    case (cur)
      S_WASH:  st = (mode == 3'd0 || mode == 3'd2) ? S_RINSE : S_DONE;
      S_RINSE: st = (mode == 3'd0 || mode == 3'd4) ? S_SPIN  : S_DONE;
      default: st = S_DONE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Panel/actuator bundle between the button front-end, the sequencer and the display stage.
interface wash_sequencer_if;
  logic       clk_sec, power_btn, start_btn, mode_btn, water_btn;
  logic       power_led, start_led, module_select, water_select;
  logic [2:0] model_now;
  logic [3:0] water_level;
  logic       if_finish;
  logic [2:0] phase;
  logic [5:0] sec_left;
  logic       motor_on, inlet_valve, drain_valve, buzzer;

  modport master (
    output clk_sec, power_btn, start_btn, mode_btn, water_btn,
    input  power_led, start_led, module_select, water_select, model_now, water_level,
           if_finish, phase, sec_left, motor_on, inlet_valve, drain_valve, buzzer
  );

  modport slave (
    input  clk_sec, power_btn, start_btn, mode_btn, water_btn,
    output power_led, start_led, module_select, water_select, model_now, water_level,
           if_finish, phase, sec_left, motor_on, inlet_valve, drain_valve, buzzer
  );
endinterface

// File: rtl/wash_sequencer_phase_timer.sv
// Phase seconds counter: load wins over decrement; expire flags the tick that ends a phase.
module wash_sequencer_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       tick,
  input  logic       en,
  output logic [5:0] count,
  output logic       expire
);

  always_ff @(posedge clk) begin
    if (!reset)                          count <= '0;
    else if (load)                       count <= load_val;
    else if (tick && en && count != '0)  count <= count - 6'd1;
  end

  assign expire = tick && (count == 6'd1);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine programme controller: power/start, mode and level selection,
// WASH->RINSE->SPIN sequencing and actuator drive. All outputs registered.
module wash_sequencer
  import wash_sequencer_pkg::*;
#(
  parameter int WASH_SEC  = WASH_SEC_DEF,
  parameter int RINSE_SEC = RINSE_SEC_DEF,
  parameter int SPIN_SEC  = SPIN_SEC_DEF,
  parameter int BUZZ_SEC  = BUZZ_SEC_DEF
) (
  input logic              clk,
  input logic              reset,
  wash_sequencer_if.slave  bus
);

  state_t     state, nxt_state, succ;
  logic       run_en, nxt_run;
  logic [2:0] model, nxt_model;
  logic [3:0] level, nxt_level;
  logic       fin, nxt_fin;
  logic [3:0] buzz_cnt, nxt_buzz;
  logic       mod_sel, wat_sel;
  logic       t_load, t_en, t_expire;
  logic [5:0] t_val, sec_left;
  logic       pwr_q, motor_q, inlet_q, drain_q, buzzer_q, mod_sel_q, wat_sel_q;

  function automatic logic [5:0] phase_len(input state_t st, input logic [3:0] lvl);
    logic [5:0] len;
    case (st)
      S_WASH:  len = 6'(WASH_SEC)  + {2'b00, lvl};
      S_RINSE: len = 6'(RINSE_SEC) + {2'b00, lvl};
      S_SPIN:  len = 6'(SPIN_SEC);
      default: len = '0;
    endcase
    return len;
  endfunction

  wash_sequencer_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .tick     (bus.clk_sec),
    .en       (t_en),
    .count    (sec_left),
    .expire   (t_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_OFF;
      run_en    <= 1'b0;
      model     <= 3'd0;
      level     <= LVL_MIN;
      fin       <= 1'b0;
      buzz_cnt  <= '0;
      pwr_q     <= 1'b0;
      motor_q   <= 1'b0;
      inlet_q   <= 1'b0;
      drain_q   <= 1'b0;
      buzzer_q  <= 1'b0;
      mod_sel_q <= 1'b0;
      wat_sel_q <= 1'b0;
    end else begin
      state     <= nxt_state;
      run_en    <= nxt_run;
      model     <= nxt_model;
      level     <= nxt_level;
      fin       <= nxt_fin;
      buzz_cnt  <= nxt_buzz;
      pwr_q     <= (nxt_state != S_OFF);
      motor_q   <= nxt_run && (nxt_state inside {S_WASH, S_RINSE, S_SPIN});
      inlet_q   <= nxt_run && (nxt_state inside {S_WASH, S_RINSE});
      drain_q   <= nxt_run && (nxt_state == S_SPIN);
      buzzer_q  <= (nxt_state == S_DONE) && (nxt_buzz != '0);
      mod_sel_q <= mod_sel;
      wat_sel_q <= wat_sel;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_run   = run_en;
    nxt_model = model;
    nxt_level = level;
    nxt_fin   = fin;
    nxt_buzz  = buzz_cnt;
    mod_sel   = 1'b0;
    wat_sel   = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;
    t_en      = 1'b0;
    succ      = next_phase(state, model);

    if (state == S_OFF) begin
      if (bus.power_btn) nxt_state = S_IDLE;
    end else if (bus.power_btn) begin
      // Power-off beats every simultaneous button or tick; selections survive.
      nxt_state = S_OFF;
      nxt_run   = 1'b0;
      nxt_fin   = 1'b0;
      nxt_buzz  = '0;
      t_load    = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_btn) begin
            nxt_state = first_phase(model);
            nxt_run   = 1'b1;
            t_load    = 1'b1;
            t_val     = phase_len(first_phase(model), level);
          end else begin
            if (bus.mode_btn) begin
              nxt_model = (model == MODE_LAST) ? 3'd0 : model + 3'd1;
              mod_sel   = 1'b1;
            end
            if (bus.water_btn) begin
              nxt_level = (level == LVL_MAX) ? LVL_MIN : level + 4'd1;
              wat_sel   = 1'b1;
            end
          end
        end
        S_WASH, S_RINSE, S_SPIN: begin
          // A pause/resume press swallows a coincident tick.
          if (bus.start_btn) begin
            nxt_run = ~run_en;
          end else if (run_en && bus.clk_sec) begin
            t_en = 1'b1;
            if (t_expire) begin
              nxt_state = succ;
              t_load    = 1'b1;
              t_val     = phase_len(succ, level);
              if (succ == S_DONE) begin
                nxt_run  = 1'b0;
                nxt_fin  = 1'b1;
                nxt_buzz = 4'(BUZZ_SEC);
              end
            end
          end
        end
        S_DONE: begin
          if (bus.start_btn) begin
            nxt_state = S_IDLE;
            nxt_fin   = 1'b0;
            nxt_buzz  = '0;
          end else if (bus.clk_sec && buzz_cnt != '0) begin
            nxt_buzz = buzz_cnt - 4'd1;
          end
        end
        default: nxt_state = S_OFF;
      endcase
    end
  end

  assign bus.power_led     = pwr_q;
  assign bus.start_led     = run_en;
  assign bus.module_select = mod_sel_q;
  assign bus.water_select  = wat_sel_q;
  assign bus.model_now     = model;
  assign bus.water_level   = level;
  assign bus.if_finish     = fin;
  assign bus.phase         = state;
  assign bus.sec_left      = sec_left;
  assign bus.motor_on      = motor_q;
  assign bus.inlet_valve   = inlet_q;
  assign bus.drain_valve   = drain_q;
  assign bus.buzzer        = buzzer_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: stimulus queues hand-computed expectations
// tagged with the cycle they apply to; a negedge monitor pops and compares them.
module tb_wash_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  wash_sequencer_if bus();

  wash_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {F_PHASE, F_SEC, F_PWR, F_RUN, F_MODEL, F_LEVEL, F_MSEL, F_WSEL,
                    F_FIN, F_MOTOR, F_INLET, F_DRAIN, F_BUZZ} fld_t;

  typedef struct {
    int    tag;
    fld_t  f;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];

  function automatic logic [31:0] get_f(input fld_t f);
    case (f)
      F_PHASE: return 32'(bus.phase);
      F_SEC:   return 32'(bus.sec_left);
      F_PWR:   return 32'(bus.power_led);
      F_RUN:   return 32'(bus.start_led);
      F_MODEL: return 32'(bus.model_now);
      F_LEVEL: return 32'(bus.water_level);
      F_MSEL:  return 32'(bus.module_select);
      F_WSEL:  return 32'(bus.water_select);
      F_FIN:   return 32'(bus.if_finish);
      F_MOTOR: return 32'(bus.motor_on);
      F_INLET: return 32'(bus.inlet_valve);
      F_DRAIN: return 32'(bus.drain_valve);
      default: return 32'(bus.buzzer);
    endcase
  endfunction

  // Expectation for the outputs produced by the inputs most recently driven.
  task automatic chk(input fld_t f, input int val, input string name);
    exp_t e;
    e.tag = cyc + 1;
    e.f = f;
    e.val = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic cyc_in(input bit p, input bit s, input bit m, input bit w, input bit t,
                        input bit rn = 1'b1);
    @(posedge clk);
    #1;
    reset = rn;
    bus.power_btn = p;
    bus.start_btn = s;
    bus.mode_btn = m;
    bus.water_btn = w;
    bus.clk_sec = t;
  endtask

  task automatic idle();
    cyc_in(0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].tag <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.tag < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.tag, cyc);
      end else if (get_f(e.f) !== 32'(e.val)) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, get_f(e.f), e.val, cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.clk_sec = 0; bus.power_btn = 0; bus.start_btn = 0; bus.mode_btn = 0; bus.water_btn = 0;

    cyc_in(0, 0, 0, 0, 0, 0);
    cyc_in(0, 0, 0, 0, 0, 0);
    chk(F_PHASE, 0, "rst_phase"); chk(F_PWR, 0, "rst_power"); chk(F_SEC, 0, "rst_sec");
    chk(F_MODEL, 0, "rst_model"); chk(F_LEVEL, 2, "rst_level"); chk(F_RUN, 0, "rst_start");
    chk(F_MOTOR, 0, "rst_motor"); chk(F_BUZZ, 0, "rst_buzz"); chk(F_FIN, 0, "rst_fin");

    cyc_in(1, 0, 0, 0, 0);
    chk(F_PWR, 1, "pwr_on_led"); chk(F_PHASE, 1, "pwr_on_idle");
    chk(F_MODEL, 0, "pwr_on_model"); chk(F_LEVEL, 2, "pwr_on_level");
    idle();

    for (int i = 0; i < 7; i++) begin
      cyc_in(0, 0, 0, 1, 0);
      chk(F_WSEL, 1, "water_sel_pulse"); chk(F_LEVEL, (i == 6) ? 2 : 3 + i, "water_level_step");
      idle();
      chk(F_WSEL, 0, "water_sel_low");
    end
    for (int i = 0; i < 6; i++) begin
      cyc_in(0, 0, 1, 0, 0);
      chk(F_MSEL, 1, "mode_sel_pulse"); chk(F_MODEL, (i + 1) % 6, "mode_step");
      idle();
      chk(F_MSEL, 0, "mode_sel_low");
    end

    // Mode 0, level 2: full programme.
    cyc_in(0, 1, 0, 0, 0);
    chk(F_PHASE, 2, "m0_wash"); chk(F_SEC, 11, "m0_wash_sec"); chk(F_RUN, 1, "m0_run");
    chk(F_MOTOR, 1, "m0_wash_motor"); chk(F_INLET, 1, "m0_wash_inlet"); chk(F_DRAIN, 0, "m0_wash_drain");
    idle();
    cyc_in(0, 0, 1, 0, 0);
    chk(F_MODEL, 0, "mode_in_wash_model"); chk(F_MSEL, 0, "mode_in_wash_sel"); chk(F_PHASE, 2, "mode_in_wash_phase");
    idle();
    for (int k = 1; k <= 11; k++) begin
      cyc_in(0, 0, 0, 0, 1);
      if (k < 11) begin
        chk(F_SEC, 11 - k, "wash_count"); chk(F_PHASE, 2, "wash_phase");
      end else begin
        chk(F_PHASE, 3, "to_rinse"); chk(F_SEC, 8, "rinse_sec");
      end
      idle();
    end
    for (int k = 1; k <= 8; k++) begin
      cyc_in(0, 0, 0, 0, 1);
      if (k < 8) begin
        chk(F_SEC, 8 - k, "rinse_count");
      end else begin
        chk(F_PHASE, 4, "to_spin"); chk(F_SEC, 3, "spin_sec"); chk(F_DRAIN, 1, "spin_drain");
        chk(F_INLET, 0, "spin_inlet"); chk(F_MOTOR, 1, "spin_motor");
      end
      idle();
    end
    for (int k = 1; k <= 3; k++) begin
      cyc_in(0, 0, 0, 0, 1);
      if (k < 3) begin
        chk(F_SEC, 3 - k, "spin_count");
      end else begin
        chk(F_PHASE, 5, "to_done"); chk(F_FIN, 1, "done_fin"); chk(F_SEC, 0, "done_sec");
        chk(F_RUN, 0, "done_run"); chk(F_BUZZ, 1, "done_buzz"); chk(F_MOTOR, 0, "done_motor");
        chk(F_DRAIN, 0, "done_drain");
      end
      idle();
    end
    cyc_in(0, 0, 0, 0, 1); chk(F_BUZZ, 1, "buzz_tick1"); idle();
    cyc_in(0, 0, 0, 0, 1); chk(F_BUZZ, 0, "buzz_tick2"); chk(F_FIN, 1, "fin_hold"); idle();
    cyc_in(0, 1, 0, 0, 0);
    chk(F_PHASE, 1, "ack_idle"); chk(F_FIN, 0, "ack_fin"); chk(F_MODEL, 0, "ack_model"); chk(F_LEVEL, 2, "ack_level");
    idle();

    // Mode 3, level 8: pause/resume behaviour.
    for (int i = 0; i < 3; i++) begin cyc_in(0, 0, 1, 0, 0); idle(); end
    for (int i = 0; i < 6; i++) begin cyc_in(0, 0, 0, 1, 0); idle(); end
    chk(F_MODEL, 3, "m3_model"); chk(F_LEVEL, 8, "m3_level");
    cyc_in(0, 1, 0, 0, 0);
    chk(F_PHASE, 3, "m3_rinse"); chk(F_SEC, 14, "m3_sec"); chk(F_MOTOR, 1, "m3_motor"); chk(F_INLET, 1, "m3_inlet");
    idle();
    for (int k = 1; k <= 4; k++) begin
      cyc_in(0, 0, 0, 0, 1); chk(F_SEC, 14 - k, "m3_count"); idle();
    end
    cyc_in(0, 1, 0, 0, 0);
    chk(F_RUN, 0, "pause_run"); chk(F_MOTOR, 0, "pause_motor"); chk(F_INLET, 0, "pause_inlet"); chk(F_SEC, 10, "pause_sec");
    idle();
    for (int k = 0; k < 5; k++) begin
      cyc_in(0, 0, 0, 0, 1); chk(F_SEC, 10, "paused_sec"); chk(F_MOTOR, 0, "paused_motor"); chk(F_PHASE, 3, "paused_phase");
      idle();
    end
    cyc_in(0, 1, 0, 0, 0); chk(F_RUN, 1, "resume_run"); chk(F_MOTOR, 1, "resume_motor"); idle();
    cyc_in(0, 0, 0, 0, 1); chk(F_SEC, 9, "resume_count"); idle();
    cyc_in(0, 1, 0, 0, 1); chk(F_RUN, 0, "start_tick_pause"); chk(F_SEC, 9, "start_tick_drop1"); idle();
    cyc_in(0, 1, 0, 0, 1); chk(F_RUN, 1, "start_tick_resume"); chk(F_SEC, 9, "start_tick_drop2"); idle();
    cyc_in(0, 0, 0, 0, 1); chk(F_SEC, 8, "after_resume_count"); idle();

    cyc_in(0, 0, 0, 0, 0, 0);
    chk(F_PHASE, 0, "midrst_phase"); chk(F_SEC, 0, "midrst_sec"); chk(F_MODEL, 0, "midrst_model");
    chk(F_LEVEL, 2, "midrst_level"); chk(F_PWR, 0, "midrst_pwr"); chk(F_RUN, 0, "midrst_run");
    chk(F_MOTOR, 0, "midrst_motor"); chk(F_FIN, 0, "midrst_fin");
    idle();

    // Mode 5: power-off coinciding with a tick during SPIN.
    cyc_in(1, 0, 0, 0, 0); chk(F_PWR, 1, "m5_pwr"); idle();
    for (int i = 0; i < 5; i++) begin cyc_in(0, 0, 1, 0, 0); idle(); end
    cyc_in(0, 1, 0, 0, 0);
    chk(F_PHASE, 4, "m5_spin"); chk(F_SEC, 3, "m5_sec"); chk(F_DRAIN, 1, "m5_drain"); chk(F_MOTOR, 1, "m5_motor");
    idle();
    cyc_in(0, 0, 0, 0, 1); chk(F_SEC, 2, "m5_count"); idle();
    cyc_in(1, 0, 0, 0, 1);
    chk(F_PHASE, 0, "poff_phase"); chk(F_PWR, 0, "poff_pwr"); chk(F_SEC, 0, "poff_sec");
    chk(F_MOTOR, 0, "poff_motor"); chk(F_DRAIN, 0, "poff_drain"); chk(F_RUN, 0, "poff_run");
    chk(F_MODEL, 5, "poff_model"); chk(F_LEVEL, 2, "poff_level"); chk(F_BUZZ, 0, "poff_buzz"); chk(F_FIN, 0, "poff_fin");
    idle();
    idle();
    #10;

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
